// File: rtl/addernet_pkg.sv
// addernet_pkg: core operand geometry, scheduler FSM encoding and lane-slice helper
package addernet_pkg;
    localparam int NBIT = 16;
    localparam int NDATA = 64;
    localparam int NRESULT = 22;
    typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    function automatic logic [NBIT-1:0] lane_slice(input logic [NBIT*NDATA-1:0] bus, input int idx);
        return bus[idx*NBIT +: NBIT];
    endfunction
endpackage

// File: rtl/addernet_lat_pipe.sv
// addernet_lat_pipe: valid shift register tracking tiles in flight through the core
module addernet_lat_pipe #(
    parameter int DEPTH = 3
) (
    input  logic CLK,
    input  logic clear,
    input  logic din,
    output logic tail
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge CLK) begin
        if (clear) sr <= '0;
        else sr <= (sr << 1) | DEPTH'(din);
    end
    assign tail = sr[DEPTH-1];
endmodule

// File: rtl/addernet_tile_sched.sv
// addernet_tile_sched: multi-tile job sequencer for the AdderNet L1 core; ADDERNET_NEG_OUT_EN negates o_acc
module addernet_tile_sched
    import addernet_pkg::*;
#(
    parameter int CORE_LAT = 2,
    parameter int TILE_W = 8,
    parameter int ACC_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_start,
    input  logic [TILE_W-1:0]     i_num_tiles,
    output logic                  o_busy,
    input  logic                  i_tile_valid,
    output logic                  o_tile_ready,
    input  logic [NBIT*NDATA-1:0] i_tile_if,
    input  logic [NBIT*NDATA-1:0] i_tile_w,
    output logic [NBIT*NDATA-1:0] o_core_if,
    output logic [NBIT*NDATA-1:0] o_core_w,
    input  logic [NRESULT:0]      i_core_result,
    output logic                  o_acc_valid,
    output logic [ACC_W-1:0]      o_acc,
    input  logic                  i_acc_ready
);
    state_t state, state_nx;
    logic [TILE_W-1:0] num, issued, returned;
    logic [ACC_W-1:0] acc;
    logic hs, tail, unused_sign;
    assign hs = i_tile_valid && o_tile_ready;
    assign unused_sign = i_core_result[NRESULT];
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (i_start) state_nx = (i_num_tiles == '0) ? DONE : FEED;
            FEED:  if (hs && issued == num - 1'b1) state_nx = DRAIN;
            DRAIN: if (returned == num) state_nx = DONE;
            DONE:  if (i_acc_ready) state_nx = IDLE;
        endcase
    end
    always_comb begin
        o_busy = state != IDLE;
        o_tile_ready = state == FEED && issued < num;
        o_acc_valid = state == DONE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            num <= '0;
            issued <= '0;
            returned <= '0;
            acc <= '0;
            o_core_if <= '0;
            o_core_w <= '0;
        end else begin
            o_core_if <= hs ? i_tile_if : '0;
            o_core_w <= hs ? i_tile_w : '0;
            if (state == IDLE && i_start) begin
                num <= i_num_tiles;
                issued <= '0;
                returned <= '0;
                acc <= '0;
            end
            if (hs) issued <= issued + 1'b1;
            if (tail) begin
                acc <= acc + ACC_W'(i_core_result[NRESULT-1:0]);
                returned <= returned + 1'b1;
            end
        end
    end
    addernet_lat_pipe #(.DEPTH(CORE_LAT + 1)) u_pipe (
        .CLK  (CLK),
        .clear(RST),
        .din  (hs),
        .tail (tail)
    );
`ifdef ADDERNET_NEG_OUT_EN
    assign o_acc = -acc;
`else
    assign o_acc = acc;
`endif
endmodule

// File: doc/addernet_tile_sched.md
Name: addernet_tile_sched

Overview:
- Sequences the AdderNet L1 core (`top`: 64 lanes x 16-bit i_if/i_w, signed 23-bit o_result = sum of |if-w|) over multi-tile jobs.
- Accepts a job length in tiles and pulls one 64-lane operand tile per cycle from an upstream valid/ready stream.
- Drives the core's operand buses and tracks the core pipeline latency.
- Accumulates per-tile core results into one job result, presented on a valid/ready output.

Parameters:
- NBIT, 16, lane operand width
- NDATA, 64, lanes per tile
- NRESULT, 22, core result MSB index (core result is NRESULT+1 bits)
- CORE_LAT, 2, cycles from o_core_if/o_core_w change to matching i_core_result; allowed range 0..8
- TILE_W, 8, width of tile-count field
- ACC_W, 32, accumulator/output width; must be >= NRESULT+1+TILE_W

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- i_start  in  1  job start pulse; sampled only in IDLE
- i_num_tiles  in  TILE_W  tiles in job; sampled with i_start
- o_busy  out  1  high from accepted start until result handshake
- i_tile_valid  in  1  upstream tile valid
- o_tile_ready  out  1  tile accepted when valid&&ready
- i_tile_if  in  NBIT*NDATA  feature tile
- i_tile_w  in  NBIT*NDATA  weight tile
- o_core_if  out  NBIT*NDATA  to core i_if (registered)
- o_core_w  out  NBIT*NDATA  to core i_w (registered)
- i_core_result  in  NRESULT+1  from core o_result, signed, non-negative in use
- o_acc_valid  out  1  job result valid
- o_acc  out  ACC_W  job result
- i_acc_ready  in  1  downstream accepts result

Behaviour:
- Reset values: o_busy=0, o_tile_ready=0, o_core_if=0, o_core_w=0, o_acc_valid=0, o_acc=0. Issue/return counters, accumulator and latency pipe are all cleared. Reset mid-job abandons the job; in-flight results are discarded.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE: o_tile_ready=0. i_start with i_num_tiles>0 latches the count, clears the accumulator, goes to FEED. i_start with i_num_tiles==0 goes directly to DONE with o_acc=0. i_start in any other state is ignored.
- FEED: o_tile_ready=1 while issued<num_tiles. On handshake, the next edge loads o_core_if/o_core_w with the tile and pushes 1 into the valid pipe; issued increments. With no handshake, o_core_* are loaded with 0 and 0 is pushed (bubble; a zero operand tile gives result 0). Leaves for DRAIN on the edge that issues the last tile.
- Valid pipe: depth CORE_LAT+1, so handshake-to-accumulate is CORE_LAT+1 cycles. When the pipe tail is 1: acc <= acc + zero-extended i_core_result[NRESULT-1:0]. The sign bit is ignored. The result has ACC_W-bit wraparound, which cannot occur within the parameter rule. returned increments.
- DRAIN: o_tile_ready=0 and o_core_* are driven to 0. Goes to DONE on the edge where returned reaches num_tiles. The final accumulate is visible on o_acc in DONE.
- DONE: o_acc_valid=1 and o_acc stable until i_acc_ready. On handshake: o_acc_valid=0, o_busy=0, next state IDLE. Holds indefinitely under backpressure.
- o_busy=1 in FEED, DRAIN and DONE.
- Throughput: one tile per cycle. Minimum job latency from start to o_acc_valid is 1 + num_tiles + CORE_LAT + 1 cycles.

Optional Feature:
- Macro: ADDERNET_NEG_OUT_EN.
- Defined: o_acc presents the two's-complement negation of the accumulator (AdderNet similarity = -L1). The internal accumulator is unchanged. A zero-tile job still outputs 0.
- Undefined: o_acc = accumulator (positive L1 distance).

Decomposition:
- Package addernet_pkg holds NBIT, NDATA, NRESULT, the FSM state encoding (2-bit: IDLE=0, FEED=1, DRAIN=2, DONE=3) and a lane-slice helper function.
- One sub-module, addernet_lat_pipe, implements the CORE_LAT+1 deep valid shift register. It has a clear input driven by RST, and CORE_LAT=0 gives a single flop.

Test Plan:
- Single tile, lanes 0-3 if {4,7,2,1} / w {5,1,3,0}, other lanes 0, CORE_LAT=2 -> o_acc_valid exactly 4 cycles after the edge where the tile handshake is sampled; o_acc=9 (negated: 0xFFFFFFF7).
- Two back-to-back tiles: tile 1 as above, tile 2 lanes 4-7 if {7,12,1,8} / w {5,1,3,0} -> o_acc=32; o_tile_ready high both cycles.
- Same two tiles with i_tile_valid low for 3 cycles between them -> o_acc=32, bubbles not accumulated, o_acc_valid delayed by 3 cycles.
- i_num_tiles=0 start -> DONE next cycle, o_acc=0; i_start pulses during FEED/DONE are ignored.
- i_acc_ready held low 10 cycles in DONE -> o_acc stable, no new tile accepted; single-cycle ready returns to IDLE with o_busy=0.
- RST asserted mid-FEED after 1 of 4 tiles -> all outputs at reset values next cycle; a new 1-tile job then returns only its own sum.
